// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: owns the PC, fetches from a single-cycle ROM into an in-order queue.
// Optional build macro IFETCH_JUMP_PREDECODE_EN follows direct jumps at fetch time with no bubble.
module ifetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              resume,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    localparam int unsigned      PTR_W      = $clog2(DEPTH);
    localparam int unsigned      CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [5:0]       OP_SYSCALL = 6'b001100;

    typedef enum logic {
        S_FETCH,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [ADDR_W-1:0] ipc_q   [DEPTH];

    logic              pop;
    logic              push;
    logic              is_syscall;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] fetch_next_pc;
    logic              unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr = pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? ipc_q[rd_ptr_q]   : '0;
    assign halted    = (state_q == S_HALT);

    assign is_syscall = (imem_data[31:26] == OP_SYSCALL);
    assign seq_pc     = pc_q + ADDR_W'(4);

`ifdef IFETCH_JUMP_PREDECODE_EN
    localparam logic [5:0] OP_JUMP = 6'b000010;
    logic is_jump;
    assign is_jump       = (imem_data[31:26] == OP_JUMP);
    assign fetch_next_pc = is_jump ? {imem_data[ADDR_W-3:0], 2'b00} : seq_pc;
`else
    assign fetch_next_pc = seq_pc;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push     = 1'b0;
        pop      = out_valid && out_ready;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // A redirect discards the whole queue, so the pop above only matters to the consumer.
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
            state_d  = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    push = (count_q != FULL_CNT) || pop;
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        pc_d     = fetch_next_pc;
                        if (is_syscall) begin
                            state_d = S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only visible through out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= imem_data;
            ipc_q[wr_ptr_q]   <= pc_q;
        end
    end

    count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= FULL_CNT);
    no_push_when_halted: assert property (@(posedge clk) disable iff (!rst_n) !(push && halted));

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomised self-checking bench for ifetch_unit against a queue-based reference model.
module tb_ifetch_unit;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          resume = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          halted;

    logic [DW-1:0] rom [64];
    assign imem_data = rom[imem_addr[7:2]];

    ifetch_unit #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .RESET_PC(8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .resume        (resume),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // {out_valid, out_instr, out_pc, imem_addr, halted}
    logic [49:0] obs;
    assign obs = {out_valid, out_instr, out_pc, imem_addr, halted};

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pc;
    } entry_t;

    entry_t mq[$];
    int     mpc;
    bit     mhalted;
    int     total = 0;
    int     bad   = 0;

`ifdef IFETCH_JUMP_PREDECODE_EN
    localparam logic [7:0] PC_AFTER_JUMP = 8'h18;
`else
    localparam logic [7:0] PC_AFTER_JUMP = 8'h30;
`endif

    function automatic logic [49:0] exp_obs();
        if (mq.size() == 0) return {1'b0, 32'h0, 8'h00, 8'(mpc), mhalted};
        return {1'b1, mq[0].instr, mq[0].pc, 8'(mpc), mhalted};
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc     = 0;
        mhalted = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model by the fetch rules, and land at posedge+1.
    task automatic step(input bit rdy, input bit rv, input logic [7:0] rpc, input bit res);
        int          sz;
        bit          pop;
        logic [31:0] w;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        resume         = res;
        sz  = mq.size();
        pop = (sz > 0) && rdy;
        w   = rom[mpc / 4];
        if (pop) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            mpc     = int'(rpc) & 'hFC;
            mhalted = 1'b0;
        end else if (mhalted) begin
            if (res) mhalted = 1'b0;
        end else if (sz < DEPTH || pop) begin
            mq.push_back(entry_t'{instr: w, pc: 8'(mpc)});
            if (w[31:26] == 6'b001100) mhalted = 1'b1;
`ifdef IFETCH_JUMP_PREDECODE_EN
            if (w[31:26] == 6'b000010) mpc = int'(w[5:0]) * 4;
            else mpc = (mpc + 4) % 256;
`else
            mpc = (mpc + 4) % 256;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; resume = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        total++;
        if (obs !== 50'h0) begin
            bad++; $display("FAIL reset_async: got %h expected %h", obs, 50'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs !== 50'h0) begin
            bad++; $display("FAIL reset_hold: got %h expected %h", obs, 50'h0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            total++;
            if (obs !== exp_obs()) begin
                bad++; $display("FAIL stream_model[%0d]: got %h expected %h", k, obs, exp_obs());
            end
            total++;
            if ({out_valid, out_pc} !== {1'b1, 8'(4 * k)}) begin
                bad++; $display("FAIL stream_pc[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, out_valid, out_pc, 8'(4 * k));
            end
            if (k == 0) begin
                total++;
                if (out_instr !== 32'h20010000) begin
                    bad++; $display("FAIL stream_first_instr: got %h expected 20010000", out_instr);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] want;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            total++;
            if (obs !== exp_obs()) begin
                bad++; $display("FAIL stall_model[%0d]: got %h expected %h", k, obs, exp_obs());
            end
        end
        total++;
        if ({out_valid, out_pc, imem_addr} !== {1'b1, 8'h00, 8'h08}) begin
            bad++; $display("FAIL stall_full: got v=%b pc=%h addr=%h expected v=1 pc=00 addr=08", out_valid, out_pc, imem_addr);
        end
        want = 8'h00;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) begin
                total++;
                if (out_pc !== want) begin
                    bad++; $display("FAIL release_order[%0d]: got %h expected %h", k, out_pc, want);
                end
                want = want + 8'd4;
            end
            step(1'b1, 1'b0, 8'h00, 1'b0);
            total++;
            if (obs !== exp_obs()) begin
                bad++; $display("FAIL release_model[%0d]: got %h expected %h", k, obs, exp_obs());
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h1B, 1'b0);
        total++;
        if ({out_valid, imem_addr} !== {1'b0, 8'h18} || obs !== exp_obs()) begin
            bad++; $display("FAIL redirect_flush: got %h expected %h", obs, exp_obs());
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 8'h18, 32'h10230005}) begin
            bad++; $display("FAIL redirect_target: got v=%b pc=%h instr=%h expected v=1 pc=18 instr=10230005", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_syscall();
        apply_reset();
        step(1'b1, 1'b1, 8'h30, 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
        total++;
        if ({halted, imem_addr, out_pc} !== {1'b1, 8'h3C, 8'h38} || obs !== exp_obs()) begin
            bad++; $display("FAIL syscall_halt: got %h expected %h", obs, exp_obs());
        end
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
        total++;
        if ({halted, imem_addr, out_valid} !== {1'b1, 8'h3C, 1'b0}) begin
            bad++; $display("FAIL syscall_drain: got h=%b addr=%h v=%b expected h=1 addr=3c v=0", halted, imem_addr, out_valid);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        total++;
        if ({halted, out_valid} !== 2'b00 || obs !== exp_obs()) begin
            bad++; $display("FAIL resume_edge: got %h expected %h", obs, exp_obs());
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        total++;
        if ({out_valid, out_pc, imem_addr} !== {1'b1, 8'h3C, 8'h40}) begin
            bad++; $display("FAIL resume_fetch: got v=%b pc=%h addr=%h expected v=1 pc=3c addr=40", out_valid, out_pc, imem_addr);
        end
    endtask

    task automatic test_jump();
        apply_reset();
        step(1'b1, 1'b1, 8'h28, 1'b0);
        repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0);
        total++;
        if ({out_valid, out_pc} !== {1'b1, 8'h2C}) begin
            bad++; $display("FAIL jump_src: got v=%b pc=%h expected v=1 pc=2c", out_valid, out_pc);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        total++;
        if ({out_valid, out_pc} !== {1'b1, PC_AFTER_JUMP} || obs !== exp_obs()) begin
            bad++; $display("FAIL jump_next: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, PC_AFTER_JUMP);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [3];
        seq[0] = 8'hF8; seq[1] = 8'hFC; seq[2] = 8'h00;
        apply_reset();
        step(1'b1, 1'b1, 8'hF8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            total++;
            if ({out_valid, out_pc} !== {1'b1, seq[k]} || obs !== exp_obs()) begin
                bad++; $display("FAIL wrap[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, out_valid, out_pc, seq[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 50'h0) begin
            bad++; $display("FAIL async_reset_clear: got %h expected %h", obs, 50'h0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        total++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 8'h00, 32'h20010000}) begin
            bad++; $display("FAIL async_reset_restart: got v=%b pc=%h instr=%h expected v=1 pc=00 instr=20010000", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_random();
        logic [7:0] hot [5];
        logic [7:0] rpc;
        hot[0] = 8'h30; hot[1] = 8'h34; hot[2] = 8'h38; hot[3] = 8'h28; hot[4] = 8'hF8;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            rpc = ($urandom_range(0, 1) == 0) ? hot[$urandom_range(0, 4)] : 8'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc, $urandom_range(0, 5) == 0);
            total++;
            if (obs !== exp_obs()) begin
                bad++; $display("FAIL random[%0d]: got %h expected %h", k, obs, exp_obs());
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (w[31:26] == 6'b001100 || w[31:26] == 6'b000010) w[31:26] = 6'b001000;
            rom[i] = w;
        end
        rom[0]  = 32'h20010000;
        rom[6]  = 32'h10230005;
        rom[11] = 32'h08000006;
        rom[14] = 32'h30000000;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_syscall();
        test_jump();
        test_wrap();
        test_async_reset();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
